rr_arbiter4: RTL and testbench

- Four-requester round-robin arbiter with a transaction-level req/gnt/eot handshake.
- It is the DUT that the arbiter bench's driver and monitor attach to: it consumes req0..3 and eot0..3, and produces gnt0..3.
- Each grant is held for a whole transaction until the owner signals end-of-transaction.
- An optional hold-timeout prevents a requester from locking the resource.

---
 rtl/arb_pkg.sv | 27 ++
 rtl/rr_pick.sv | 46 ++++
 rtl/rr_arbiter4.sv | 162 ++++++++++++++++
 tb/tb_rr_arbiter4.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// | arb_pkg                                                                 |
// | Shared types and helpers for the four-way round-robin arbiter.          |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

package arb_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] idx_t;

    // Labels carry an S_ prefix so they never collide with the GAP parameter.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    function automatic idx_t next_idx(input idx_t i);
        return idx_t'(i + idx_t'(1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// | rr_pick                                                                 |
// | Combinational rotating-priority encoder: first req at ptr, ptr+1, ...   |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  idx_t             ptr_i,
    output logic             valid_o,
    output idx_t             idx_o
);

    logic [N_REQ-1:0] w_rot;
    idx_t             w_off;

    // w_rot[k] is the request sitting k places after the pointer.
    always_comb begin
        w_rot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_rot[k] = req_i[idx_t'(ptr_i + idx_t'(k))];
        end
    end

    always_comb begin
        w_off = 2'd0;
        if (w_rot[0]) begin
            w_off = 2'd0;
        end else if (w_rot[1]) begin
            w_off = 2'd1;
        end else if (w_rot[2]) begin
            w_off = 2'd2;
        end else if (w_rot[3]) begin
            w_off = 2'd3;
        end
    end

    assign valid_o = |w_rot;
    assign idx_o   = idx_t'(ptr_i + w_off);

endmodule

`default_nettype wire

// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// | rr_arbiter4                                                             |
// | Four-requester round-robin arbiter, grant held until eot/abandon/limit. |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 0,
    parameter int GAP      = 0,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       req2,
    input  logic       req3,
    input  logic       eot0,
    input  logic       eot1,
    input  logic       eot2,
    input  logic       eot3,
    output logic       gnt0,
    output logic       gnt1,
    output logic       gnt2,
    output logic       gnt3,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout,
    output logic       stray_eot
);

    localparam logic [CW-1:0] C_HOLD_LAST = (MAX_HOLD != 0) ? CW'(MAX_HOLD - 1) : '0;
    localparam logic [CW-1:0] C_GAP_LAST  = (GAP != 0) ? CW'(GAP - 1) : '0;
    localparam logic [CW-1:0] C_CNT_MAX   = '1;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    idx_t              owner_q, owner_d;
    idx_t              ptr_q, ptr_d;
    logic [CW-1:0]     hold_q, hold_d;
    logic [CW-1:0]     gap_q, gap_d;
    logic              timeout_q, timeout_d;
    logic              stray_q, stray_d;

    logic [N_REQ-1:0]  w_req;
    logic [N_REQ-1:0]  w_eot;
    logic [N_REQ-1:0]  w_stray;
    logic              w_pick_valid;
    idx_t              w_pick_idx;
    logic              w_rel_eot;
    logic              w_rel_abandon;
    logic              w_rel_hold;
    logic              w_release;

    assign w_req = {req3, req2, req1, req0};
    assign w_eot = {eot3, eot2, eot1, eot0};

    rr_pick u_pick (
        .req_i   (w_req),
        .ptr_i   (ptr_q),
        .valid_o (w_pick_valid),
        .idx_o   (w_pick_idx)
    );

    // gnt_q is one-hot on the owner only in GRANT, so any eot outside it is stray.
    assign w_stray       = w_eot & ~gnt_q;
    assign w_rel_eot     = w_eot[owner_q];
    assign w_rel_abandon = ~w_req[owner_q];
    assign w_rel_hold    = (MAX_HOLD != 0) && (hold_q == C_HOLD_LAST);
    assign w_release     = (state_q == S_GRANT) && (w_rel_eot || w_rel_abandon || w_rel_hold);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        timeout_d = 1'b0;
        stray_d   = stray_q | (|w_stray);

        case (state_q)
            S_IDLE: begin
                if (w_pick_valid) begin
                    gnt_d             = '0;
                    gnt_d[w_pick_idx] = 1'b1;
                    owner_d           = w_pick_idx;
                    hold_d            = '0;
                    state_d           = S_GRANT;
                end
            end

            S_GRANT: begin
                if (hold_q != C_CNT_MAX) begin
                    hold_d = hold_q + CW'(1);
                end
                if (w_release) begin
                    gnt_d     = '0;
                    ptr_d     = next_idx(owner_q);
                    // An eot or abandon on the same edge masks the timeout.
                    timeout_d = w_rel_hold & ~w_rel_eot & ~w_rel_abandon;
                    if (GAP > 0) begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_GAP: begin
                if (gap_q == C_GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + CW'(1);
                end
            end

            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            gap_q     <= '0;
            timeout_q <= 1'b0;
            stray_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            timeout_q <= timeout_d;
            stray_q   <= stray_d;
        end
    end

    assign gnt0      = gnt_q[0];
    assign gnt1      = gnt_q[1];
    assign gnt2      = gnt_q[2];
    assign gnt3      = gnt_q[3];
    assign owner     = owner_q;
    assign busy      = |gnt_q;
    assign timeout   = timeout_q;
    assign stray_eot = stray_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
// ---------------------------------------------------------------------------
// | tb_rr_arbiter4                                                          |
// | Scoreboard bench: two arbiter configurations against a reference model. |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_rr_arbiter4;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       timeout;
        logic       stray;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0;
    logic [3:0] eot = 4'b0;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] own_a, own_b;
    logic       busy_a, busy_b, to_a, to_b, se_a, se_b;

    int total = 0;
    int bad   = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    // Reference model: instance 0 = MAX_HOLD 5 / GAP 0, instance 1 = MAX_HOLD 0 / GAP 3.
    int m_g[2];      // current grantee, -1 when nobody holds the resource
    int m_held[2];   // cycles the current grant has lasted
    int m_wait[2];   // remaining forced idle cycles after a release
    int m_ptr[2];
    int m_own[2];
    bit m_to[2];
    bit m_st[2];
    int P_MAXH[2] = '{5, 0};
    int P_GAP[2]  = '{0, 3};

    always #5 clk = ~clk;

    rr_arbiter4 #(.MAX_HOLD(5), .GAP(0), .CW(8)) dut_a (
        .clk(clk), .rst(rst),
        .req0(req[0]), .req1(req[1]), .req2(req[2]), .req3(req[3]),
        .eot0(eot[0]), .eot1(eot[1]), .eot2(eot[2]), .eot3(eot[3]),
        .gnt0(gnt_a[0]), .gnt1(gnt_a[1]), .gnt2(gnt_a[2]), .gnt3(gnt_a[3]),
        .owner(own_a), .busy(busy_a), .timeout(to_a), .stray_eot(se_a)
    );

    rr_arbiter4 #(.MAX_HOLD(0), .GAP(3), .CW(8)) dut_b (
        .clk(clk), .rst(rst),
        .req0(req[0]), .req1(req[1]), .req2(req[2]), .req3(req[3]),
        .eot0(eot[0]), .eot1(eot[1]), .eot2(eot[2]), .eot3(eot[3]),
        .gnt0(gnt_b[0]), .gnt1(gnt_b[1]), .gnt2(gnt_b[2]), .gnt3(gnt_b[3]),
        .owner(own_b), .busy(busy_b), .timeout(to_b), .stray_eot(se_b)
    );

    task automatic model_step(input int m, input bit r, input logic [3:0] rq, input logic [3:0] eo);
        bit rel_e, rel_a, rel_t, found;
        int idx;
        if (r) begin
            m_g[m] = -1; m_held[m] = 0; m_wait[m] = 0;
            m_ptr[m] = 0; m_own[m] = 0; m_to[m] = 0; m_st[m] = 0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (eo[i] && m_g[m] != i) m_st[m] = 1;
        end
        m_to[m] = 0;
        if (m_g[m] >= 0) begin
            m_held[m]++;
            rel_e = eo[m_g[m]];
            rel_a = !rq[m_g[m]];
            rel_t = (P_MAXH[m] != 0) && (m_held[m] == P_MAXH[m]);
            if (rel_e || rel_a || rel_t) begin
                m_to[m]   = rel_t && !rel_e && !rel_a;
                m_ptr[m]  = (m_g[m] + 1) % 4;
                m_g[m]    = -1;
                m_wait[m] = P_GAP[m];
            end
        end else if (m_wait[m] > 0) begin
            m_wait[m]--;
        end else begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr[m] + k) % 4;
                if (!found && rq[idx]) begin
                    found = 1;
                    m_g[m] = idx; m_own[m] = idx; m_held[m] = 0;
                end
            end
        end
    endtask

    function automatic exp_t model_out(input int m);
        exp_t e;
        e.gnt     = (m_g[m] >= 0) ? (4'b0001 << m_g[m]) : 4'b0000;
        e.owner   = 2'(m_own[m]);
        e.busy    = (m_g[m] >= 0);
        e.timeout = m_to[m];
        e.stray   = m_st[m];
        return e;
    endfunction

    task automatic push_expected(input bit r, input logic [3:0] rq, input logic [3:0] eo);
        model_step(0, r, rq, eo);
        model_step(1, r, rq, eo);
        q_a.push_back(model_out(0));
        q_b.push_back(model_out(1));
    endtask

    task automatic cycle(input bit r, input logic [3:0] rq, input logic [3:0] eo);
        @(negedge clk);
        rst = r;
        req = rq;
        eot = eo;
        push_expected(r, rq, eo);
    endtask

    // Reset is raised between edges; outputs must clear without a clock.
    task automatic mid_reset(input logic [3:0] rq);
        @(negedge clk);
        req = rq;
        eot = 4'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (gnt_a !== 4'b0 || gnt_b !== 4'b0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: gnt_a=%b gnt_b=%b busy_a=%b busy_b=%b, want all zero",
                     gnt_a, gnt_b, busy_a, busy_b);
        end
        push_expected(1'b1, rq, 4'b0);
    endtask

    task automatic check(input string nm, input exp_t act, input exp_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got gnt=%b owner=%0d busy=%b timeout=%b stray=%b, want gnt=%b owner=%0d busy=%b timeout=%b stray=%b",
                     nm, $time, act.gnt, act.owner, act.busy, act.timeout, act.stray,
                     exp.gnt, exp.owner, exp.busy, exp.timeout, exp.stray);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q_a.size() > 0) begin
            e_a = q_a.pop_front();
            check("dut_a", {gnt_a, own_a, busy_a, to_a, se_a}, e_a);
        end
        if (q_b.size() > 0) begin
            e_b = q_b.pop_front();
            check("dut_b", {gnt_b, own_b, busy_b, to_b, se_b}, e_b);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rq;
        logic [3:0] eo;

        // Reset, then a quiet idle stretch.
        cycle(1'b1, 4'b0, 4'b0);
        cycle(1'b1, 4'b0, 4'b0);
        repeat (10) cycle(1'b0, 4'b0, 4'b0);

        // All requesting; each owner of dut_a ends on its 3rd granted cycle.
        for (int n = 0; n < 20; n++) begin
            eo = (m_g[0] >= 0 && m_held[0] == 2) ? (4'b0001 << m_g[0]) : 4'b0000;
            cycle(1'b0, 4'b1111, eo);
        end

        // Lone requester 2 with no eot: hold limit on dut_a.
        cycle(1'b1, 4'b0, 4'b0);
        repeat (14) cycle(1'b0, 4'b0100, 4'b0);

        // Requester 2 ends exactly on its 5th cycle: no timeout.
        cycle(1'b1, 4'b0, 4'b0);
        for (int n = 0; n < 10; n++) begin
            eo = (m_g[0] == 2 && m_held[0] == 4) ? 4'b0100 : 4'b0000;
            cycle(1'b0, 4'b0100, eo);
        end

        // Owner 1, stray eot3, then abandon; requester 3 must beat requester 0.
        cycle(1'b1, 4'b0, 4'b0);
        cycle(1'b0, 4'b0010, 4'b0);
        cycle(1'b0, 4'b1010, 4'b0);
        cycle(1'b0, 4'b1010, 4'b1000);
        repeat (2) cycle(1'b0, 4'b1010, 4'b0);
        repeat (7) cycle(1'b0, 4'b1001, 4'b0);

        // Gap spacing on dut_b, then reset while a grant is live.
        cycle(1'b1, 4'b0, 4'b0);
        for (int n = 0; n < 12; n++) begin
            eo = (m_g[1] == 0 && m_held[1] == 0) ? 4'b0001 : 4'b0000;
            cycle(1'b0, 4'b0011, eo);
        end
        mid_reset(4'b0011);
        repeat (4) cycle(1'b0, 4'b0011, 4'b0);

        // Randomised traffic with sticky-ish request levels.
        rq = 4'b0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(3) == 0) rq[i] = ~rq[i];
            end
            eo = 4'b0;
            if (m_g[0] >= 0 && $urandom_range(3) == 0) eo[m_g[0]] = 1'b1;
            if (m_g[1] >= 0 && $urandom_range(3) == 0) eo[m_g[1]] = 1'b1;
            if ($urandom_range(19) == 0) eo[$urandom_range(3)] = 1'b1;
            if ($urandom_range(149) == 0) mid_reset(rq);
            else cycle(1'b0, rq, eo);
        end

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d/%0d expectations left, want 0/0", q_a.size(), q_b.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
